// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: port ids, response owner tag, defaults.
package dmem_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int unsigned DMEM_LATENCY      = 1;
  localparam int unsigned DEFAULT_MAX_BURST = 4;

  typedef struct packed {
    logic valid;
    logic port;
  } owner_tag_t;

endpackage

// File: rtl/rr_burst_arb.sv
// Two-input round-robin arbiter with a bounded burst allowance.
// Holds the priority pointer, last owner and consecutive-grant count.
module rr_burst_arb import dmem_pkg::*; #(
  parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  logic       ptr_q;
  logic       owner_q;
  logic [3:0] cnt_q;
  logic       gnt_port;
  logic       contested;
  logic [3:0] cnt_next;

  always_comb begin
    contested = &valid;
    gnt_port  = ptr_q;
    if (valid == 2'b01) begin
      gnt_port = PORT_A;
    end else if (valid == 2'b10) begin
      gnt_port = PORT_B;
    end else if (contested && owner_q == ptr_q && cnt_q >= MaxBurst) begin
      gnt_port = ~ptr_q;
    end
    grant = 2'b00;
    if (|valid) begin
      grant = gnt_port ? 2'b10 : 2'b01;
    end
    // Count saturates so a long uncontested run cannot wrap back below the limit.
    if (owner_q == gnt_port && cnt_q != 4'd0) begin
      cnt_next = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    end else begin
      cnt_next = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= PORT_A;
      owner_q <= PORT_A;
      cnt_q   <= 4'd0;
    end else if (!(|valid)) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q   <= cnt_next;
      owner_q <= gnt_port;
      if (contested && cnt_next >= MaxBurst) begin
        ptr_q <= ~gnt_port;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the 1-cycle-latency data memory.
// Optional per-port grant and stall counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter import dmem_pkg::*; #(
  parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic              mem_r_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_out
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       a_grant_cnt,
  output logic [15:0]       b_grant_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  logic [1:0]        grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  owner_tag_t        tag_q;

  rr_burst_arb #(
    .MAX_BURST(MAX_BURST)
  ) u_arb (
    .clk    (clk),
    .reset_n(reset_n),
    .valid  ({b_req_valid, a_req_valid}),
    .grant  (grant)
  );

  assign a_req_ready = grant[0];
  assign b_req_ready = grant[1];

  // Idle cycles replay the last address/data so the banks see no toggling.
  always_comb begin
    mem_r_w  = 1'b0;
    mem_addr = addr_q;
    mem_data = data_q;
    unique case (grant)
      2'b01: begin
        mem_r_w  = a_req_we;
        mem_addr = a_req_addr;
        mem_data = a_req_wdata;
      end
      2'b10: begin
        mem_r_w  = b_req_we;
        mem_addr = b_req_addr;
        mem_data = b_req_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      data_q <= '0;
      tag_q  <= '0;
    end else begin
      if (|grant) begin
        addr_q <= mem_addr;
        data_q <= mem_data;
      end
      tag_q.valid <= (|grant) && !mem_r_w;
      tag_q.port  <= grant[1] ? PORT_B : PORT_A;
    end
  end

  assign a_rsp_valid = tag_q.valid && (tag_q.port == PORT_A);
  assign b_rsp_valid = tag_q.valid && (tag_q.port == PORT_B);
  assign a_rsp_rdata = a_rsp_valid ? mem_out : '0;
  assign b_rsp_rdata = b_rsp_valid ? mem_out : '0;

`ifdef DMEM_ARB_STATS_EN
  logic stall;
  assign stall = (a_req_valid && !grant[0]) || (b_req_valid && !grant[1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (grant[0] && a_grant_cnt != 16'hFFFF) a_grant_cnt <= a_grant_cnt + 16'd1;
      if (grant[1] && b_grant_cnt != 16'hFFFF) b_grant_cnt <= b_grant_cnt + 16'd1;
      if (stall && stall_cnt != 16'hFFFF)      stall_cnt   <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
